// File: rtl/scan_pkg.sv
// scan_pkg -- shared constants and types for the channel scan sequencer.
//   NUM_CH   : number of scanned channels
//   DW       : channel data width
//   SEL_W    : width of the mux select / channel index
//   SEL_PARK : select value driven while idle (downstream mux returns 0)
//   state_e  : sequencer states
package scan_pkg;
    localparam int NUM_CH = 6;
    localparam int DW     = 4;
    localparam int SEL_W  = 3;
    localparam logic [SEL_W-1:0] SEL_PARK = 3'h7;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SEND
    } state_e;
endpackage

// File: rtl/chan_scan_seq_if.sv
// chan_scan_seq_if -- request, mux and output-stream signals of the sequencer.
//   req       : per-channel level request           (to sequencer)
//   sel       : registered select to external mux   (from sequencer)
//   mux_out   : mux data for the current sel        (to sequencer)
//   gnt       : one-hot one-cycle grant pulse       (from sequencer)
//   out_data  : captured channel data               (from sequencer)
//   out_ch    : channel index of out_data           (from sequencer)
//   out_valid : out_data/out_ch valid               (from sequencer)
//   out_ready : consumer accepts the word           (to sequencer)
// master = sequencer side, slave = environment side.
interface chan_scan_seq_if
    import scan_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int DW     = 4
);
    logic [NUM_CH-1:0] req;
    logic [SEL_W-1:0]  sel;
    logic [DW-1:0]     mux_out;
    logic [NUM_CH-1:0] gnt;
    logic [DW-1:0]     out_data;
    logic [SEL_W-1:0]  out_ch;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  req, mux_out, out_ready,
        output sel, gnt, out_data, out_ch, out_valid
    );

    modport slave (
        output req, mux_out, out_ready,
        input  sel, gnt, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/chan_scan_seq_rr_pick.sv
// rr_pick -- combinational winner selection.
//   req : per-channel requests
//   ptr : channel the scan starts from (0 for fixed priority)
//   win : first set request at or above ptr, wrapping past the top channel
//   any : at least one request is set
module rr_pick
    import scan_pkg::*;
#(
    parameter int NUM_CH = 6
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  win,
    output logic              any
);
    localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);

    logic [2*NUM_CH-1:0] rot;
    logic [SEL_W-1:0]    off;
    logic [SEL_W:0]      sum;

    // Rotating the doubled vector puts channel ptr at bit 0, so the lowest
    // set bit of the rotated word is the offset of the wrapped winner.
    assign rot = {req, req} >> ptr;

    always_comb begin
        off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NCH) sum = sum - NCH;
        win = sum[SEL_W-1:0];
        any = |req;
    end
endmodule

// File: rtl/chan_scan_seq.sv
// chan_scan_seq -- scans request lines, steers an external mux to the
// winning channel, captures its data and offers it on a valid/ready stream.
//   clk    : clock, rising edge
//   areset : asynchronous active-high reset
//   bus    : chan_scan_seq_if.master (req, sel, mux_out, gnt, out_*)
// Build option: SCAN_FIXED_PRIO_EN -- lowest requesting channel always wins
// and no scan pointer is kept; default is round-robin from ptr.
module chan_scan_seq
    import scan_pkg::*;
#(
    parameter int NUM_CH = scan_pkg::NUM_CH,
    parameter int DW     = scan_pkg::DW
) (
    input  logic            clk,
    input  logic            areset,
    chan_scan_seq_if.master bus
);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  win;
    logic              any;

`ifdef SCAN_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [SEL_W-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`endif

    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        gnt_d       = '0;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
`ifndef SCAN_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any) begin
                    sel_d   = win;
                    state_d = CAPTURE;
                end else begin
                    sel_d   = SEL_PARK;
                end
            end
            CAPTURE: begin
                // sel_q still holds the winner, so the mux data is its word
                // even if its request has since dropped.
                out_data_d  = bus.mux_out;
                out_ch_d    = sel_q;
                out_valid_d = 1'b1;
                gnt_d       = {{(NUM_CH-1){1'b0}}, 1'b1} << sel_q;
`ifndef SCAN_FIXED_PRIO_EN
                ptr_d       = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
`endif
                state_d     = SEND;
            end
            SEND: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    sel_d       = SEL_PARK;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            sel_q       <= SEL_PARK;
            gnt_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
`ifndef SCAN_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
`ifndef SCAN_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_chan_scan_seq.sv
// tb_chan_scan_seq -- directed bench for chan_scan_seq: a per-cycle vector
// table plus hand-written sequences for round-robin order, back-pressure,
// pointer wrap and asynchronous reset during SEND.
module tb_chan_scan_seq;
    import scan_pkg::*;

`ifdef SCAN_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    chan_scan_seq_if bus_if ();

    chan_scan_seq dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus_if)
    );

    // External 6:1 mux model; park value returns 0.
    logic [DW-1:0] chan_data [NUM_CH];
    always_comb begin
        bus_if.mux_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus_if.sel == 3'(i)) bus_if.mux_out = chan_data[i];
        end
    end

    int pass_cnt = 0;
    int tot_cnt  = 0;

    typedef struct {
        logic [5:0]  req;
        logic        rdy;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [31:0] pk(input logic [2:0] s, input logic [5:0] g,
                                       input logic v, input logic [3:0] d,
                                       input logic [2:0] c);
        return {15'b0, s, g, v, d, c};
    endfunction

    function automatic logic [31:0] obs();
        return pk(bus_if.sel, bus_if.gnt, bus_if.out_valid, bus_if.out_data, bus_if.out_ch);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        bus_if.req = '0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
    endtask

    // Steps until a word is offered (bounded); returns its channel, data and
    // the OR of every grant seen on the way.
    task automatic serve_one(output logic [2:0] ch, output logic [3:0] d,
                             output logic [5:0] g_or, output bit ok);
        ok = 1'b0; ch = '0; d = '0; g_or = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            g_or |= bus_if.gnt;
            if (bus_if.out_valid) begin
                ok = 1'b1;
                ch = bus_if.out_ch;
                d  = bus_if.out_data;
            end
        end
    endtask

    initial begin
        logic [2:0] ch;
        logic [3:0] d;
        logic [5:0] g_or;
        bit ok;
        int n, last;

        chan_data = '{4'h1, 4'h2, 4'hA, 4'h3, 4'h4, 4'h5};
        bus_if.req = '0;
        bus_if.out_ready = 1'b0;

        // ---- per-cycle table: req, out_ready, expected {sel,gnt,valid,data,ch}
        vecs.push_back('{6'b000100, 1'b1, pk(3'd2, 6'b000000, 1'b0, 4'h0, 3'd0)});
        vecs.push_back('{6'b000000, 1'b1, pk(3'd2, 6'b000100, 1'b1, 4'hA, 3'd2)});
        vecs.push_back('{6'b000000, 1'b1, pk(3'd7, 6'b000000, 1'b0, 4'hA, 3'd2)});
        vecs.push_back('{6'b000000, 1'b1, pk(3'd7, 6'b000000, 1'b0, 4'hA, 3'd2)});
        vecs.push_back('{6'b000011, 1'b0, pk(3'd0, 6'b000000, 1'b0, 4'hA, 3'd2)});
        vecs.push_back('{6'b100000, 1'b0, pk(3'd0, 6'b000001, 1'b1, 4'h1, 3'd0)});
        vecs.push_back('{6'b100000, 1'b0, pk(3'd0, 6'b000000, 1'b1, 4'h1, 3'd0)});
        vecs.push_back('{6'b100000, 1'b1, pk(3'd7, 6'b000000, 1'b0, 4'h1, 3'd0)});
        vecs.push_back('{6'b000011, 1'b1, FIXED ? pk(3'd0, 6'b000000, 1'b0, 4'h1, 3'd0)
                                                 : pk(3'd1, 6'b000000, 1'b0, 4'h1, 3'd0)});
        vecs.push_back('{6'b000000, 1'b1, FIXED ? pk(3'd0, 6'b000001, 1'b1, 4'h1, 3'd0)
                                                 : pk(3'd1, 6'b000010, 1'b1, 4'h2, 3'd1)});
        vecs.push_back('{6'b000000, 1'b1, FIXED ? pk(3'd7, 6'b000000, 1'b0, 4'h1, 3'd0)
                                                 : pk(3'd7, 6'b000000, 1'b0, 4'h2, 3'd1)});

        do_reset();
        check("reset_state", obs(), pk(3'd7, 6'b0, 1'b0, 4'h0, 3'd0));

        foreach (vecs[i]) begin
            bus_if.req = vecs[i].req;
            bus_if.out_ready = vecs[i].rdy;
            step();
            check($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // ---- all channels requesting, consumer always ready
        do_reset();
        bus_if.req = 6'b111111;
        bus_if.out_ready = 1'b1;
        n = 0; last = 0;
        for (int cyc = 0; cyc < 40 && n < 7; cyc++) begin
            step();
            if (bus_if.out_valid) begin
                check($sformatf("rr_ch%0d", n), 32'(bus_if.out_ch), FIXED ? 32'd0 : 32'(n % 6));
                if (n > 0) check($sformatf("rr_gap%0d", n), 32'(cyc - last), 32'd3);
                last = cyc;
                n++;
            end
        end
        check("rr_words", 32'(n), 32'd7);

        // ---- back-pressure: word held while out_ready is low
        do_reset();
        bus_if.req = 6'b000010;
        serve_one(ch, d, g_or, ok);
        check("bp_ok", 32'(ok), 32'd1);
        check("bp_word", {25'b0, ch, d}, {25'b0, 3'd1, 4'h2});
        bus_if.req = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_hold%0d", i), obs(), pk(3'd1, 6'b0, 1'b1, 4'h2, 3'd1));
        end
        bus_if.out_ready = 1'b1;
        step();
        check("bp_release", obs(), pk(3'd7, 6'b0, 1'b0, 4'h2, 3'd1));

        // ---- ptr=1 with channels 5 and 0 requesting
        do_reset();
        bus_if.req = 6'b000001;
        bus_if.out_ready = 1'b1;
        serve_one(ch, d, g_or, ok);
        check("wrap_first", {28'b0, ok, ch}, {28'b0, 1'b1, 3'd0});
        bus_if.req = 6'b100001;
        serve_one(ch, d, g_or, ok);
        check("wrap_second", {28'b0, ok, ch}, {28'b0, 1'b1, FIXED ? 3'd0 : 3'd5});
        serve_one(ch, d, g_or, ok);
        check("wrap_third", {28'b0, ok, ch}, {28'b0, 1'b1, 3'd0});

        // ---- asynchronous reset while a word is pending in SEND
        do_reset();
        bus_if.req = 6'b000100;
        serve_one(ch, d, g_or, ok);
        check("ar_pending", {28'b0, ok, ch}, {28'b0, 1'b1, 3'd2});
        #2 areset = 1'b1;
        #1;
        check("ar_immediate", obs(), pk(3'd7, 6'b0, 1'b0, 4'h0, 3'd0));
        bus_if.req = '0;
        @(posedge clk);
        #1 areset = 1'b0;
        bus_if.req = 6'b001000;
        bus_if.out_ready = 1'b1;
        step();
        check("ar_no_stale", obs(), pk(3'd3, 6'b0, 1'b0, 4'h0, 3'd0));
        serve_one(ch, d, g_or, ok);
        check("ar_word", {22'b0, ok, g_or, ch}, {22'b0, 1'b1, 6'b001000, 3'd3});
        check("ar_data", 32'(d), 32'h3);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/chan_scan_seq.md
CHAN_SCAN_SEQ -- requirements
Module: chan_scan_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, giving the number of scanned channels.
REQ-002 SHALL have parameter DW, default 4, giving the channel data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_CH  per-channel request, level-sensitive.
REQ-006 SHALL have port sel  output  3  registered select driven to the downstream 6:1 data mux.
REQ-007 SHALL have port mux_out  input  DW  data returned by that mux for the current sel.
REQ-008 SHALL have port gnt  output  NUM_CH  one-hot, one-cycle grant pulse to the served channel.
REQ-009 SHALL have port out_data  output  DW  captured channel data.
REQ-010 SHALL have port out_ch  output  3  index of the channel in out_data.
REQ-011 SHALL have port out_valid  output  1  out_data/out_ch valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the word.

Function
REQ-013 SHALL implement FSM states IDLE, CAPTURE, SEND.
REQ-014 IDLE: when any req bit is set, SHALL pick a winner w, register sel<=w, and go to CAPTURE; otherwise stay in IDLE with sel=3'h7 (park value; the mux outputs 0).
REQ-015 Winner SHALL be the first set req bit scanning upward from pointer ptr, wrapping 5->0.
REQ-016 CAPTURE: SHALL register out_data<=mux_out, out_ch<=sel, and out_valid<=1, pulse gnt[w] for exactly this cycle, set ptr<=w+1 (w=5 wraps to 0), and go to SEND.
REQ-017 SEND: SHALL hold out_data, out_ch, and out_valid stable until out_ready=1.
REQ-018 On an out_valid&&out_ready handshake, SHALL set out_valid<=0 and sel<=3'h7 and return to IDLE.
REQ-019 Latency from req sampled in IDLE to out_valid SHALL be 2 cycles; peak throughput SHALL be 1 word per 3 cycles.
REQ-020 Deassertion of req[w] after it is sampled in IDLE SHALL NOT cancel the capture.
REQ-021 New requests arriving in CAPTURE or SEND SHALL be held off until the next IDLE.
REQ-022 out_ready while out_valid=0 SHALL be ignored.
REQ-023 The arbitration decision SHALL depend only on the registered ptr and the current req.

Reset
REQ-024 areset SHALL immediately (asynchronously) force: state=IDLE, ptr=0, sel=3'h7, gnt=0, out_data=0, out_ch=0, out_valid=0.
REQ-025 Reset asserted mid-CAPTURE or mid-SEND SHALL drop the in-flight word; no gnt SHALL be issued after release until a fresh IDLE arbitration.
REQ-026 The first arbitration after reset release SHALL start from channel 0.

Configuration
REQ-027 Macro SCAN_FIXED_PRIO_EN defined: selection SHALL be fixed priority (lowest set req index wins), and ptr SHALL be neither stored nor updated.
REQ-028 Macro SCAN_FIXED_PRIO_EN undefined (default): round-robin selection per REQ-015/016 SHALL apply.

Structure
REQ-029 Package scan_pkg SHALL hold NUM_CH, DW, SEL_W=3, SEL_PARK=3'h7, and the state enum (IDLE, CAPTURE, SEND).
REQ-030 Winner selection SHALL live in one combinational sub-module, rr_pick (inputs req and ptr; outputs winner index and any-valid).

Verification
REQ-031 Reset then req=6'b000100, mux_out=4'hA: sel=2 next cycle, then gnt=6'b000100 pulse, out_valid=1, out_data=4'hA, out_ch=2.
REQ-032 req=6'b111111 held, out_ready=1: out_ch sequence 0,1,2,3,4,5,0, with one word every 3 cycles.
REQ-033 Word pending, out_ready=0 for 5 cycles: out_valid, out_data, and out_ch stay stable and sel stays at winner; first cycle with out_ready=1 -> out_valid=0 next cycle, sel=7.
REQ-034 req=6'b100001 with ptr=1: channel 5 served before 0; with SCAN_FIXED_PRIO_EN: channel 0 every time.
REQ-035 areset pulsed during SEND: out_valid=0 and sel=7 immediately; after release with req=6'b001000, out_ch=3 with no stale word.
